// File: rtl/red_pitaya_exp_in_pkg.sv
// Shared constants for the expansion-connector input conditioning block.
package red_pitaya_exp_in_pkg;

    // Default geometry: pins per bank and debounce counter width.
    localparam int DW_DEF  = 8;
    localparam int DBW_DEF = 20;

    // Register offsets within the block's bus slot (sys_addr[19:0]).
    localparam logic [19:0] REG_DBLEN = 20'h00000;
    localparam logic [19:0] REG_PSTAT = 20'h00004;
    localparam logic [19:0] REG_NSTAT = 20'h00008;
    localparam logic [19:0] REG_PRISE = 20'h0000C;
    localparam logic [19:0] REG_PFALL = 20'h00010;
    localparam logic [19:0] REG_NRISE = 20'h00014;
    localparam logic [19:0] REG_NFALL = 20'h00018;
    localparam logic [19:0] REG_MASK  = 20'h0001C;

    // Sticky latch update: clear requested bits, but a fresh edge always wins.
    function automatic logic [DW_DEF-1:0] latch_next(
        input logic [DW_DEF-1:0] cur,
        input logic [DW_DEF-1:0] clr,
        input logic [DW_DEF-1:0] set
    );
        return (cur & ~clr) | set;
    endfunction

endpackage

// File: rtl/red_pitaya_exp_in_pin.sv
// One expansion pin: 2-FF synchroniser, debounce filter and edge pulses.
module red_pitaya_exp_in_pin
    import red_pitaya_exp_in_pkg::*;
#(
    parameter int DBW = DBW_DEF
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           pad_i,
    input  logic [DBW-1:0] db_len_i,
    output logic           stable_o,
    output logic           rise_o,
    output logic           fall_o
);

    logic           sync1_q;
    logic           sync2_q;
    logic           stable_q;
    logic           stable_d;
    logic [DBW-1:0] cnt_q;
    logic [DBW-1:0] cnt_d;
    logic           rise_q;
    logic           rise_d;
    logic           fall_q;
    logic           fall_d;

    // Debounce decision: commit the synchronised level once it has differed
    // from the stable level for more than db_len cycles.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q >= db_len_i) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            rise_d   = sync2_q;
            fall_d   = ~sync2_q;
        end else begin
            cnt_d = cnt_q + DBW'(1);
        end
    end

    // Synchroniser chain, filter state and one-cycle edge pulses.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= pad_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/red_pitaya_exp_in.sv
// Expansion-connector input conditioning: per-pin filters, sticky edge
// latches, maskable interrupt and a small register slot on the system bus.
module red_pitaya_exp_in
    import red_pitaya_exp_in_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int DBW = DBW_DEF
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [DW-1:0] exp_p_pad_i,
    input  logic [DW-1:0] exp_n_pad_i,
    output logic [DW-1:0] exp_p_dat_o,
    output logic [DW-1:0] exp_n_dat_o,
    output logic          irq_o,
    input  logic [31:0]   sys_addr,
    input  logic [31:0]   sys_wdata,
    input  logic [3:0]    sys_sel,
    input  logic          sys_wen,
    input  logic          sys_ren,
    output logic [31:0]   sys_rdata,
    output logic          sys_err,
    output logic          sys_ack
);

    logic [DW-1:0]   p_stable_s, n_stable_s;
    logic [DW-1:0]   p_rise_s, p_fall_s, n_rise_s, n_fall_s;
    logic [DBW-1:0]  db_len_q, db_len_d;
    logic [2*DW-1:0] mask_q, mask_d;
    logic [DW-1:0]   p_rise_q, p_fall_q, n_rise_q, n_fall_q;
    logic [DW-1:0]   p_rise_d, p_fall_d, n_rise_d, n_fall_d;
    logic            irq_q;
    logic            irq_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ack_q;
    logic [19:0]     addr_s;
    logic [DW-1:0]   clr_s;
    logic            unused_bits_s;

    assign addr_s = sys_addr[19:0];
    assign clr_s  = sys_wdata[DW-1:0];

    // Byte selects and upper address/data bits carry no meaning here.
    assign unused_bits_s = &{1'b0, sys_sel, sys_addr[31:20], sys_wdata[31:DBW]};

    genvar g;
    generate
        for (g = 0; g < DW; g++) begin : g_pin
            red_pitaya_exp_in_pin #(.DBW(DBW)) u_p (
                .clk_i    (clk_i),
                .rstn_i   (rstn_i),
                .pad_i    (exp_p_pad_i[g]),
                .db_len_i (db_len_q),
                .stable_o (p_stable_s[g]),
                .rise_o   (p_rise_s[g]),
                .fall_o   (p_fall_s[g])
            );
            red_pitaya_exp_in_pin #(.DBW(DBW)) u_n (
                .clk_i    (clk_i),
                .rstn_i   (rstn_i),
                .pad_i    (exp_n_pad_i[g]),
                .db_len_i (db_len_q),
                .stable_o (n_stable_s[g]),
                .rise_o   (n_rise_s[g]),
                .fall_o   (n_fall_s[g])
            );
        end
    endgenerate

    // Configuration writes and sticky-latch updates (W1C, set beats clear).
    always_comb begin
        db_len_d = db_len_q;
        mask_d   = mask_q;
        p_rise_d = latch_next(p_rise_q, (sys_wen && addr_s == REG_PRISE) ? clr_s : '0, p_rise_s);
        p_fall_d = latch_next(p_fall_q, (sys_wen && addr_s == REG_PFALL) ? clr_s : '0, p_fall_s);
        n_rise_d = latch_next(n_rise_q, (sys_wen && addr_s == REG_NRISE) ? clr_s : '0, n_rise_s);
        n_fall_d = latch_next(n_fall_q, (sys_wen && addr_s == REG_NFALL) ? clr_s : '0, n_fall_s);
        if (sys_wen) begin
            case (addr_s)
                REG_DBLEN: db_len_d = sys_wdata[DBW-1:0];
                REG_MASK:  mask_d   = sys_wdata[2*DW-1:0];
                default:   db_len_d = db_len_q;
            endcase
        end else begin
            db_len_d = db_len_q;
        end
    end

    // Interrupt level from masked latches, P bank in the low half.
    always_comb begin
        irq_d = |({n_rise_q | n_fall_q, p_rise_q | p_fall_q} & mask_q);
    end

    // Read mux; reads see register values before any same-cycle write.
    always_comb begin
        rdata_d = 32'h0000_0000;
        if (sys_ren) begin
            case (addr_s)
                REG_DBLEN: rdata_d = 32'(db_len_q);
                REG_PSTAT: rdata_d = 32'(p_stable_s);
                REG_NSTAT: rdata_d = 32'(n_stable_s);
                REG_PRISE: rdata_d = 32'(p_rise_q);
                REG_PFALL: rdata_d = 32'(p_fall_q);
                REG_NRISE: rdata_d = 32'(n_rise_q);
                REG_NFALL: rdata_d = 32'(n_fall_q);
                REG_MASK:  rdata_d = 32'(mask_q);
                default:   rdata_d = 32'h0000_0000;
            endcase
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // Register state, interrupt and bus response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            db_len_q <= '0;
            mask_q   <= '0;
            p_rise_q <= '0;
            p_fall_q <= '0;
            n_rise_q <= '0;
            n_fall_q <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= 32'h0000_0000;
            ack_q    <= 1'b0;
        end else begin
            db_len_q <= db_len_d;
            mask_q   <= mask_d;
            p_rise_q <= p_rise_d;
            p_fall_q <= p_fall_d;
            n_rise_q <= n_rise_d;
            n_fall_q <= n_fall_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
            ack_q    <= sys_wen | sys_ren;
        end
    end

    assign exp_p_dat_o = p_stable_s;
    assign exp_n_dat_o = n_stable_s;
    assign irq_o       = irq_q;
    assign sys_rdata   = rdata_q;
    assign sys_ack     = ack_q;
    assign sys_err     = 1'b0;

endmodule
